// File: rtl/simon_stream_pkg.sv
// Shared types and constants for the Simon 128/128 byte-stream front end.
package simon_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_PT,
    START,
    WAIT_CT,
    SEND_CT
  } state_t;

  localparam int         BLOCK_BYTES = 16;
  localparam logic [7:0] CMD_KEY_DEF = 8'h4B;
  localparam logic [7:0] CMD_PT_DEF  = 8'h50;

endpackage

// File: rtl/simon_byte_serializer.sv
// 128-bit load/shift register emitting 16 bytes MSB first over valid/ready.
import simon_stream_pkg::*;

module simon_byte_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] data_i,
  output logic [7:0]   out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         done_o
);

  logic [127:0] sh_q, sh_d;
  logic         busy_q, busy_d;
  logic [3:0]   cnt_q, cnt_d;

  always_comb begin
    sh_d   = sh_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    done_o = 1'b0;
    if (load_i) begin
      sh_d   = data_i;
      busy_d = 1'b1;
      cnt_d  = 4'd0;
    end else if (busy_q && out_ready_i) begin
      sh_d  = {sh_q[119:0], 8'h00};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
        busy_d = 1'b0;
        done_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_data_o  = sh_q[127:120];
  assign out_valid_o = busy_q;

endmodule

// File: rtl/simon_stream_ctrl.sv
// Command-framed byte link to Simon 128/128 core: loads key/pt,
// starts the core, and streams the ciphertext back as 16 bytes.
module simon_stream_ctrl
  import simon_stream_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 256,
  parameter logic [7:0] CMD_KEY        = CMD_KEY_DEF,
  parameter logic [7:0] CMD_PT         = CMD_PT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [7:0]   out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         start_o,
  output logic [127:0] pt_o,
  output logic [127:0] k0_o,
  input  logic         valid_i,
  input  logic [127:0] ct_i,
  output logic         key_loaded_o,
  output logic         err_o
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [127:0]   k0_q, k0_d;
  logic [127:0]   pt_q, pt_d;
  logic           key_ld_q, key_ld_d;
  logic           err_q, err_d;
  logic           ser_load;
  logic           ser_done;
  logic           last_byte;

  assign last_byte = (cnt_q == 4'(BLOCK_BYTES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    k0_d       = k0_q;
    pt_d       = pt_q;
    key_ld_d   = key_ld_q;
    err_d      = 1'b0;
    in_ready_o = 1'b0;
    start_o    = 1'b0;
    ser_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        cnt_d      = 4'd0;
        if (in_valid_i) begin
          if (in_data_i == CMD_KEY)     state_d = LOAD_KEY;
          else if (in_data_i == CMD_PT) state_d = LOAD_PT;
          else                          err_d   = 1'b1;
        end
      end
      LOAD_KEY: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          k0_d  = {k0_q[119:0], in_data_i};
          cnt_d = cnt_q + 4'd1;
          if (last_byte) begin
            state_d  = IDLE;
            key_ld_d = 1'b1;
          end
        end
      end
      LOAD_PT: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          pt_d  = {pt_q[119:0], in_data_i};
          cnt_d = cnt_q + 4'd1;
          if (last_byte) state_d = START;
        end
      end
      START: begin
        start_o = 1'b1;
        wd_d    = '0;
        state_d = WAIT_CT;
      end
      WAIT_CT: begin
        if (valid_i) begin
          ser_load = 1'b1;
          state_d  = SEND_CT;
        end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      SEND_CT: begin
        if (ser_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wd_q     <= '0;
      k0_q     <= '0;
      pt_q     <= '0;
      key_ld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      k0_q     <= k0_d;
      pt_q     <= pt_d;
      key_ld_q <= key_ld_d;
      err_q    <= err_d;
    end
  end

  simon_byte_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ser_load),
    .data_i      (ct_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .done_o      (ser_done)
  );

  assign k0_o         = k0_q;
  assign pt_o         = pt_q;
  assign key_loaded_o = key_ld_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_simon_stream_ctrl.sv
// Directed bench for simon_stream_ctrl with a behavioural core stub.
module tb_simon_stream_ctrl;

  localparam logic [127:0] KEY    = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT     = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] XOR_CT = 128'h6c7d68682b797b6d6b6a607262707520;
  localparam logic [127:0] REF_CT = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data_i = '0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [7:0]   out_data_o;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic         start_o;
  logic [127:0] pt_o;
  logic [127:0] k0_o;
  logic         valid_i = 1'b0;
  logic [127:0] ct_i = '0;
  logic         key_loaded_o;
  logic         err_o;

  int n_chk  = 0;
  int n_pass = 0;
  int mode   = 0;

  simon_stream_ctrl #(.TIMEOUT_CYCLES(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .start_o      (start_o),
    .pt_o         (pt_o),
    .k0_o         (k0_o),
    .valid_i      (valid_i),
    .ct_i         (ct_i),
    .key_loaded_o (key_loaded_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  // Core stub: mode 0 -> pt^key, 1 -> never valid, 2 -> reference ct.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (start_o) begin
        repeat (10) @(posedge clk);
        #1;
        if (mode != 1) begin
          ct_i    = (mode == 2) ? REF_CT : (pt_o ^ k0_o);
          valid_i = 1'b1;
          @(posedge clk); #1;
          valid_i = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int  n = 0;
    bit  rdy;
    in_data_i  = b;
    in_valid_i = 1'b1;
    do begin
      rdy = in_ready_o;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
    in_valid_i = 1'b0;
    if (!rdy) chk("send_to", 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] v,
                            input int nb);
    send_byte(cmd);
    for (int i = 0; i < nb; i++) send_byte(v[127-8*i -: 8]);
  endtask

  task automatic recv(input bit tog, input int nmax,
                      output logic [127:0] got, output int n);
    int         cyc = 0;
    bit         ph = 1'b1;
    bit         stalled = 1'b0;
    logic [7:0] pd = '0;
    got = '0;
    n   = 0;
    while (n < nmax && cyc < 400) begin
      out_ready_i = tog ? ph : 1'b1;
      ph = ~ph;
      if (stalled) chk("stall_data", out_data_o, pd);
      if (out_valid_o) chk("send_inrdy", in_ready_o, 0);
      stalled = out_valid_o && !out_ready_i;
      pd      = out_data_o;
      if (out_valid_o && out_ready_i) begin
        got = {got[119:0], out_data_o};
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready_i = 1'b0;
    if (cyc >= 400) chk("recv_to", n, nmax);
  endtask

  logic [127:0] got;
  int           nx;
  int           k;
  bit           saw_out;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_inrdy", in_ready_o, 1);
    chk("rst_outs", {out_valid_o, err_o, key_loaded_o, start_o}, 0);
    chk("rst_data", {out_data_o, pt_o ^ k0_o, k0_o[7:0]}, 0);

    // Key + pt^key stub, no backpressure
    mode = 0;
    send_frame(8'h4B, KEY, 16);
    chk("k0", k0_o, KEY);
    chk("key_ld", key_loaded_o, 1);
    send_frame(8'h50, PT, 16);
    chk("start_lat", start_o, 1);
    chk("pt", pt_o, PT);
    @(posedge clk); #1;
    chk("start_1cyc", start_o, 0);
    chk("wait_inrdy", in_ready_o, 0);
    recv(0, 16, got, nx);
    chk("xor_ct", got, XOR_CT);
    chk("xor_n", nx, 16);
    chk("end_ovld", out_valid_o, 0);
    chk("end_inrdy", in_ready_o, 1);

    // Reference ciphertext with toggling backpressure
    mode = 2;
    send_frame(8'h50, PT, 16);
    recv(1, 16, got, nx);
    chk("ref_ct", got, REF_CT);
    chk("ref_ovld", out_valid_o, 0);
    chk("ref_inrdy", in_ready_o, 1);

    // Unknown command, then encryption without a key
    send_byte(8'h00);
    chk("bad_err", err_o, 1);
    chk("bad_inrdy", in_ready_o, 1);
    @(posedge clk); #1;
    chk("bad_err_1cyc", err_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mode = 0;
    send_frame(8'h50, PT, 16);
    chk("nokey_k0", k0_o, 0);
    chk("nokey_err", err_o, 0);
    recv(0, 16, got, nx);
    chk("nokey_ct", got, PT);

    // Watchdog timeout
    mode = 1;
    send_frame(8'h50, PT, 16);
    k = 0;
    saw_out = 1'b0;
    do begin
      @(posedge clk); #1;
      k++;
      if (out_valid_o) saw_out = 1'b1;
    end while (!err_o && k < 40);
    chk("to_cycles", k, 21);
    chk("to_noout", saw_out, 0);
    chk("to_inrdy", in_ready_o, 1);
    @(posedge clk); #1;
    chk("to_err_1cyc", err_o, 0);
    chk("to_inrdy2", in_ready_o, 1);

    // Reset on 8th pt byte
    mode = 0;
    send_frame(8'h4B, KEY, 16);
    send_frame(8'h50, PT, 7);
    in_data_i  = PT[71:64];
    in_valid_i = 1'b1;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    in_valid_i = 1'b0;
    chk("rst8_keyld", key_loaded_o, 0);
    chk("rst8_regs", pt_o | k0_o, 0);
    chk("rst8_inrdy", in_ready_o, 1);

    // Reset mid-SEND_CT
    send_frame(8'h4B, KEY, 16);
    send_frame(8'h50, PT, 16);
    recv(0, 5, got, nx);
    chk("part_ct", got[39:0], XOR_CT[127:88]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rsts_ovld", out_valid_o, 0);
    chk("rsts_data", out_data_o, 0);
    chk("rsts_inrdy", in_ready_o, 1);
    chk("rsts_keyld", key_loaded_o, 0);

    // Full transaction after reset
    send_frame(8'h4B, KEY, 16);
    send_frame(8'h50, PT, 16);
    recv(0, 16, got, nx);
    chk("final_ct", got, XOR_CT);
    chk("final_ovld", out_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
